// File: rtl/rambus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rambus_pkg
//  Description : Shared types and constants for the shared-RAM Wishbone
//                arbiter: FSM state encoding, port identifiers and the
//                latched Wishbone request record.
//  Revision    : 1.0 - initial release
// ============================================================================
package rambus_pkg;

    // Word address width of the 256 x 32-bit RAM macro
    localparam int RAMBUS_AW = 8;

    // Arbiter transaction sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Master identifiers (A = project rambus, B = Caravel host)
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    // One latched Wishbone request
    typedef struct packed {
        logic                 we;
        logic [3:0]           sel;
        logic [RAMBUS_AW-1:0] adr;
        logic [31:0]          dat;
    } wb_req_t;

    // Byte write mask presented to the RAM: reads never write any lane
    function automatic logic [3:0] eff_wmask(input logic we, input logic [3:0] sel);
        return we ? sel : 4'b0000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rambus_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rambus_rr_arb
//  Description : Two-input round-robin grant. A lone requester always wins;
//                on a tie the port that did not win last time is chosen.
//                Purely combinational - the parent owns last_grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rambus_rr_arb
    import rambus_pkg::*;
(
    input  logic  i_req_a,
    input  logic  i_req_b,
    input  port_t i_last_grant,
    output logic  o_valid,
    output port_t o_grant
);

    // Pick the winner: single requester, or the opposite of last winner on a tie
    always_comb begin
        o_valid = i_req_a | i_req_b;
        o_grant = PORT_A;
        if (i_req_a && i_req_b) begin
            o_grant = (i_last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (i_req_b) begin
            o_grant = PORT_B;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rambus_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rambus_ram_arbiter
//  Description : Arbitrates the project rambus Wishbone master (port A) and
//                the Caravel host Wishbone path (port B) onto one
//                single-port OpenRAM macro. One transaction in flight,
//                round-robin between the masters, all outputs registered.
//                AW must not exceed RAMBUS_AW (the latched address width).
//  Revision    : 1.0 - initial release
// ============================================================================
module rambus_ram_arbiter
    import rambus_pkg::*;
#(
    parameter int AW          = RAMBUS_AW,
    parameter int RAM_LATENCY = 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    // Port A (project rambus)
    input  logic          a_stb_i,
    input  logic          a_cyc_i,
    input  logic          a_we_i,
    input  logic [3:0]    a_sel_i,
    input  logic [31:0]   a_dat_i,
    input  logic [AW-1:0] a_adr_i,
    output logic          a_ack_o,
    output logic [31:0]   a_dat_o,
    // Port B (Caravel host)
    input  logic          b_stb_i,
    input  logic          b_cyc_i,
    input  logic          b_we_i,
    input  logic [3:0]    b_sel_i,
    input  logic [31:0]   b_dat_i,
    input  logic [AW-1:0] b_adr_i,
    output logic          b_ack_o,
    output logic [31:0]   b_dat_o,
    // RAM macro
    output logic          ram_csb_o,
    output logic          ram_web_o,
    output logic [3:0]    ram_wmask_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_din_o,
    input  logic [31:0]   ram_dout_i
);

    // Wait counter sized to hold RAM_LATENCY-1
    localparam int                 c_CNT_W    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(RAM_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Registered state
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    port_t              r_grant;
    port_t              r_last_grant;
    wb_req_t            r_req;      // .sel doubles as the live RAM write mask
    logic               r_csb;
    logic               r_web;
    logic               r_a_ack;
    logic               r_b_ack;
    logic [31:0]        r_a_dat;
    logic [31:0]        r_b_dat;

    // Next-state values
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    port_t              w_grant_nxt;
    port_t              w_last_nxt;
    wb_req_t            w_req_nxt;
    logic               w_csb_nxt;
    logic               w_web_nxt;
    logic               w_a_ack_nxt;
    logic               w_b_ack_nxt;
    logic [31:0]        w_a_dat_nxt;
    logic [31:0]        w_b_dat_nxt;

    // Arbitration
    logic    w_a_req;
    logic    w_b_req;
    logic    w_gnt_valid;
    port_t   w_gnt;
    wb_req_t w_a_pkt;
    wb_req_t w_b_pkt;
    wb_req_t w_req_sel;

    assign w_a_req = a_cyc_i & a_stb_i;
    assign w_b_req = b_cyc_i & b_stb_i;

    assign w_a_pkt = '{we: a_we_i, sel: a_sel_i, adr: RAMBUS_AW'(a_adr_i), dat: a_dat_i};
    assign w_b_pkt = '{we: b_we_i, sel: b_sel_i, adr: RAMBUS_AW'(b_adr_i), dat: b_dat_i};
    assign w_req_sel = (w_gnt == PORT_B) ? w_b_pkt : w_a_pkt;

    rambus_rr_arb u_arb (
        .i_req_a      (w_a_req),
        .i_req_b      (w_b_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_gnt_valid),
        .o_grant      (w_gnt)
    );

    // Sequencer: next state plus next values of every registered output
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last_grant;
        w_req_nxt     = r_req;
        w_req_nxt.sel = 4'b0000;      // mask is live only while issuing
        w_csb_nxt     = 1'b1;
        w_web_nxt     = 1'b1;
        w_a_ack_nxt   = 1'b0;
        w_b_ack_nxt   = 1'b0;
        w_a_dat_nxt   = r_a_dat;
        w_b_dat_nxt   = r_b_dat;

        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_grant_nxt   = w_gnt;
                    w_last_nxt    = w_gnt;
                    w_req_nxt     = w_req_sel;
                    w_req_nxt.sel = eff_wmask(w_req_sel.we, w_req_sel.sel);
                    w_csb_nxt     = 1'b0;
                    w_web_nxt     = ~w_req_sel.we;
                    w_state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                // RAM captures the command at the end of this cycle
                if (r_req.we) begin
                    w_a_ack_nxt = (r_grant == PORT_A) && a_cyc_i;
                    w_b_ack_nxt = (r_grant == PORT_B) && b_cyc_i;
                    w_state_nxt = ACK;
                end else begin
                    w_cnt_nxt   = c_CNT_INIT;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    // Read data lands even for an aborted master; only the ack is gated
                    if (r_grant == PORT_A) begin
                        w_a_dat_nxt = ram_dout_i;
                        w_a_ack_nxt = a_cyc_i;
                    end else begin
                        w_b_dat_nxt = ram_dout_i;
                        w_b_ack_nxt = b_cyc_i;
                    end
                    w_state_nxt = ACK;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and arbitration history registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_grant      <= PORT_A;
            r_last_grant <= PORT_B;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    // Request latch, RAM command and Wishbone response registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_req   <= '0;
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_a_dat <= '0;
            r_b_dat <= '0;
        end else begin
            r_req   <= w_req_nxt;
            r_csb   <= w_csb_nxt;
            r_web   <= w_web_nxt;
            r_a_ack <= w_a_ack_nxt;
            r_b_ack <= w_b_ack_nxt;
            r_a_dat <= w_a_dat_nxt;
            r_b_dat <= w_b_dat_nxt;
        end
    end

    assign ram_csb_o   = r_csb;
    assign ram_web_o   = r_web;
    assign ram_wmask_o = r_req.sel;
    assign ram_addr_o  = AW'(r_req.adr);
    assign ram_din_o   = r_req.dat;
    assign a_ack_o     = r_a_ack;
    assign a_dat_o     = r_a_dat;
    assign b_ack_o     = r_b_ack;
    assign b_dat_o     = r_b_dat;

endmodule
`default_nettype wire

// File: tb/tb_rambus_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rambus_ram_arbiter
//  Description : Self-checking bench for rambus_ram_arbiter. A transaction
//                level scoreboard predicts acks, read data and RAM command
//                cycles; directed sequences add literal expectations. A
//                second instance runs with a 3-cycle RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rambus_ram_arbiter;

    localparam int AW  = 8;
    localparam int LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 1 (RAM_LATENCY = 1) ----------------
    logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [3:0]    a_sel, b_sel;
    logic [31:0]   a_dat, b_dat;
    logic [AW-1:0] a_adr, b_adr;
    wire           a_ack, b_ack;
    wire  [31:0]   a_rdat, b_rdat;
    wire           ram_csb, ram_web;
    wire  [3:0]    ram_wmask;
    wire  [AW-1:0] ram_addr;
    wire  [31:0]   ram_din;
    logic [31:0]   ram_dout;

    rambus_ram_arbiter #(.AW(AW), .RAM_LATENCY(LAT)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .a_stb_i(a_stb), .a_cyc_i(a_cyc), .a_we_i(a_we), .a_sel_i(a_sel),
        .a_dat_i(a_dat), .a_adr_i(a_adr), .a_ack_o(a_ack), .a_dat_o(a_rdat),
        .b_stb_i(b_stb), .b_cyc_i(b_cyc), .b_we_i(b_we), .b_sel_i(b_sel),
        .b_dat_i(b_dat), .b_adr_i(b_adr), .b_ack_o(b_ack), .b_dat_o(b_rdat),
        .ram_csb_o(ram_csb), .ram_web_o(ram_web), .ram_wmask_o(ram_wmask),
        .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
    );

    // ---------------- DUT 2 (RAM_LATENCY = 3) ----------------
    logic          d2_cyc, d2_stb, d2_we, d2_bz;
    logic [3:0]    d2_sel, d2_bsel;
    logic [31:0]   d2_dat, d2_bdat;
    logic [AW-1:0] d2_adr, d2_badr;
    wire           d2_ack, d2_back;
    wire  [31:0]   d2_rdat, d2_brdat;
    wire           d2_csb, d2_web;
    wire  [3:0]    d2_wmask;
    wire  [AW-1:0] d2_addr;
    wire  [31:0]   d2_din;
    logic [31:0]   d2_dout;

    rambus_ram_arbiter #(.AW(AW), .RAM_LATENCY(3)) u_dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .a_stb_i(d2_stb), .a_cyc_i(d2_cyc), .a_we_i(d2_we), .a_sel_i(d2_sel),
        .a_dat_i(d2_dat), .a_adr_i(d2_adr), .a_ack_o(d2_ack), .a_dat_o(d2_rdat),
        .b_stb_i(d2_bz), .b_cyc_i(d2_bz), .b_we_i(d2_bz), .b_sel_i(d2_bsel),
        .b_dat_i(d2_bdat), .b_adr_i(d2_badr), .b_ack_o(d2_back), .b_dat_o(d2_brdat),
        .ram_csb_o(d2_csb), .ram_web_o(d2_web), .ram_wmask_o(d2_wmask),
        .ram_addr_o(d2_addr), .ram_din_o(d2_din), .ram_dout_i(d2_dout)
    );

    // ---------------- RAM macro models ----------------
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];
    logic [31:0] pipe1;
    logic [31:0] pipe2 [3];

    always @(posedge clk) begin
        if (!ram_csb) begin
            if (!ram_web) begin
                for (int i = 0; i < 4; i++)
                    if (ram_wmask[i]) mem1[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
            end else begin
                pipe1 <= mem1[ram_addr];
            end
        end
    end
    assign ram_dout = pipe1;

    always @(posedge clk) begin
        pipe2[1] <= pipe2[0];
        pipe2[2] <= pipe2[1];
        if (!d2_csb) begin
            if (!d2_web) begin
                for (int i = 0; i < 4; i++)
                    if (d2_wmask[i]) mem2[d2_addr][8*i +: 8] <= d2_din[8*i +: 8];
            end else begin
                pipe2[0] <= mem2[d2_addr];
            end
        end
    end
    assign d2_dout = pipe2[2];

    // ---------------- Checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: a grant at cycle n issues at n+1, acks at
    // n+2 (write) or n+2+LAT (read); the arbiter is free again after the ack.
    int          m_issue = -1, m_ack = -1, m_free = 0;
    bit          m_port, m_we, m_last = 1'b1, m_ack_en;
    logic [3:0]  m_sel;
    logic [7:0]  m_adr;
    logic [31:0] m_dat, m_rdata;
    logic [31:0] m_mem [256];
    bit          cmp_en = 1'b0;
    bit          e_issue, e_ack, ra, rb;

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                e_issue = (cyc == m_issue);
                e_ack   = (cyc == m_ack) && m_ack_en;
                chk($sformatf("csb@%0d", cyc), ram_csb, e_issue ? 32'd0 : 32'd1);
                chk($sformatf("web@%0d", cyc), ram_web, (e_issue && m_we) ? 32'd0 : 32'd1);
                chk($sformatf("wmask@%0d", cyc), ram_wmask, (e_issue && m_we) ? m_sel : 4'h0);
                if (e_issue) begin
                    chk($sformatf("addr@%0d", cyc), ram_addr, m_adr);
                    if (m_we) chk($sformatf("din@%0d", cyc), ram_din, m_dat);
                end
                chk($sformatf("a_ack@%0d", cyc), a_ack, (e_ack && !m_port) ? 32'd1 : 32'd0);
                chk($sformatf("b_ack@%0d", cyc), b_ack, (e_ack && m_port) ? 32'd1 : 32'd0);
                if (e_ack && !m_we)
                    chk($sformatf("rdata@%0d", cyc), m_port ? b_rdat : a_rdat, m_rdata);

                // advance the model with the inputs seen at the coming edge
                if (cyc + 1 == m_ack) m_ack_en = m_port ? b_cyc : a_cyc;
                if (rst) begin
                    m_issue = -1; m_ack = -1; m_free = cyc + 1; m_last = 1'b1;
                end else if (cyc >= m_free) begin
                    ra = a_cyc && a_stb;
                    rb = b_cyc && b_stb;
                    if (ra || rb) begin
                        m_port = (ra && rb) ? !m_last : rb;
                        m_last = m_port;
                        m_we   = m_port ? b_we  : a_we;
                        m_sel  = m_port ? b_sel : a_sel;
                        m_adr  = m_port ? b_adr : a_adr;
                        m_dat  = m_port ? b_dat : a_dat;
                        m_issue  = cyc + 1;
                        m_ack_en = 1'b0;
                        if (m_we) begin
                            for (int i = 0; i < 4; i++)
                                if (m_sel[i]) m_mem[m_adr][8*i +: 8] = m_dat[8*i +: 8];
                            m_ack = cyc + 2;
                        end else begin
                            m_rdata = m_mem[m_adr];
                            m_ack   = cyc + 2 + LAT;
                        end
                        m_free = m_ack + 1;
                    end
                end
            end
        end
    end

    // Ack history and RAM-cycle counting
    int a_ack_cnt = 0, csb_lo_cnt = 0;
    int ack_log [$];
    initial begin
        forever begin
            @(negedge clk);
            if (a_ack) begin a_ack_cnt++; ack_log.push_back(0); end
            if (b_ack) ack_log.push_back(1);
            if (!ram_csb) csb_lo_cnt++;
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic drive(input bit port, input bit on, input bit we, input logic [3:0] sel,
                         input logic [7:0] adr, input logic [31:0] dat);
        if (!port) begin
            a_cyc = on; a_stb = on; a_we = we; a_sel = sel; a_adr = adr; a_dat = dat;
        end else begin
            b_cyc = on; b_stb = on; b_we = we; b_sel = sel; b_adr = adr; b_dat = dat;
        end
    endtask

    // Issue one request (called just after a rising edge), wait for its ack
    task automatic tx(input bit port, input bit we, input logic [3:0] sel, input logic [7:0] adr,
                      input logic [31:0] dat, input bit hold, output int lat, output logic [31:0] rd);
        int n0;
        bit got;
        drive(port, 1'b1, we, sel, adr, dat);
        n0 = cyc; got = 1'b0; lat = -1; rd = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (port ? b_ack : a_ack) begin
                got = 1'b1; lat = cyc - n0; rd = port ? b_rdat : a_rdat;
            end
        end
        if (!got) chk($sformatf("ack_timeout_port%0d", port), 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!hold) drive(port, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    task automatic tx2(input bit we, input logic [7:0] adr, input logic [31:0] dat,
                       output int lat, output logic [31:0] rd);
        int n0;
        bit got;
        d2_cyc = 1'b1; d2_stb = 1'b1; d2_we = we; d2_sel = 4'hF; d2_adr = adr; d2_dat = dat;
        n0 = cyc; got = 1'b0; lat = -1; rd = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (d2_ack) begin got = 1'b1; lat = cyc - n0; rd = d2_rdat; end
        end
        if (!got) chk("d2_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        d2_cyc = 1'b0; d2_stb = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- Directed sequence ----------------
    int          lat, lat_a, lat_b, la1, la2, a0, c0, n0;
    logic [31:0] rd, rd_a, rd_b, rd1, rd2;

    initial begin
        for (int i = 0; i < 256; i++) begin mem1[i] = '0; mem2[i] = '0; m_mem[i] = '0; end
        pipe1 = '0;
        for (int i = 0; i < 3; i++) pipe2[i] = '0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        d2_cyc = 0; d2_stb = 0; d2_we = 0; d2_sel = 0; d2_dat = 0; d2_adr = 0;
        d2_bz = 0; d2_bsel = 0; d2_bdat = 0; d2_badr = 0;
        rst = 1'b1;
        @(posedge clk); #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_csb", ram_csb, 1);   chk("rst_web", ram_web, 1);
        chk("rst_wmask", ram_wmask, 0); chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);   chk("rst_a_ack", a_ack, 0);
        chk("rst_b_ack", b_ack, 0);   chk("rst_a_dat", a_rdat, 0);
        chk("rst_b_dat", b_rdat, 0);
        @(posedge clk); #1;

        // 1: write on A, RAM command in N+1, ack in N+2
        n0 = cyc;
        drive(1'b0, 1'b1, 1'b1, 4'hF, 8'h12, 32'hDEADBEEF);
        @(negedge clk);
        @(negedge clk);
        chk("t1_csb", ram_csb, 0); chk("t1_web", ram_web, 0); chk("t1_wmask", ram_wmask, 4'hF);
        @(negedge clk);
        chk("t1_ack", a_ack, 1); chk("t1_lat", cyc - n0, 2);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);

        // 2: read on B, ack in N+3
        a0 = a_ack_cnt;
        tx(1'b1, 1'b0, 4'hF, 8'h12, 32'h0, 1'b0, lat, rd);
        chk("t2_lat", lat, 3); chk("t2_data", rd, 32'hDEADBEEF);
        chk("t2_no_a_ack", a_ack_cnt - a0, 0);

        // 3: simultaneous requests, A keeps stb across its ack -> A,B,A
        ack_log.delete();
        c0 = csb_lo_cnt;
        fork
            begin
                tx(1'b0, 1'b1, 4'hF, 8'h30, 32'h11111111, 1'b1, la1, rd1);
                tx(1'b0, 1'b1, 4'hF, 8'h31, 32'h22222222, 1'b0, la2, rd2);
            end
            tx(1'b1, 1'b1, 4'hF, 8'h32, 32'h33333333, 1'b0, lat_b, rd_b);
        join
        chk("t3_nacks", ack_log.size(), 3);
        if (ack_log.size() == 3) begin
            chk("t3_first", ack_log[0], 0);
            chk("t3_second", ack_log[1], 1);
            chk("t3_third", ack_log[2], 0);
        end
        chk("t3_ram_cycles", csb_lo_cnt - c0, 3);

        // 4: byte-lane write merges into existing word; sel=0 write changes nothing
        tx(1'b0, 1'b1, 4'b0010, 8'h12, 32'h0000AB00, 1'b0, lat, rd);
        tx(1'b0, 1'b0, 4'hF, 8'h12, 32'h0, 1'b0, lat, rd);
        chk("t4_merge", rd, 32'hDEADABEF);
        tx(1'b1, 1'b1, 4'h0, 8'h12, 32'hFFFFFFFF, 1'b0, lat, rd);
        chk("t4_sel0_ack_lat", lat, 2);
        tx(1'b1, 1'b0, 4'hF, 8'h12, 32'h0, 1'b0, lat, rd);
        chk("t4_sel0_data", rd, 32'hDEADABEF);

        // 5: A read aborted during WAIT, then B is served normally
        a0 = a_ack_cnt;
        drive(1'b0, 1'b1, 1'b0, 4'hF, 8'h12, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        repeat (4) @(negedge clk);
        chk("t5_no_ack", a_ack_cnt - a0, 0);
        @(posedge clk); #1;
        tx(1'b1, 1'b0, 4'hF, 8'h30, 32'h0, 1'b0, lat, rd);
        chk("t5_b_lat", lat, 3); chk("t5_b_data", rd, 32'h11111111);

        // 6: reset during ISSUE of a write
        drive(1'b0, 1'b1, 1'b1, 4'hF, 8'h40, 32'h5555AAAA);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        @(negedge clk);
        chk("t6_issue_csb", ram_csb, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_csb", ram_csb, 1); chk("t6_a_ack", a_ack, 0); chk("t6_b_ack", b_ack, 0);
        @(posedge clk); #1;
        // last grant returns to B on reset, so A wins the first tie
        ack_log.delete();
        fork
            tx(1'b0, 1'b0, 4'hF, 8'h40, 32'h0, 1'b0, lat_a, rd_a);
            tx(1'b1, 1'b0, 4'hF, 8'h12, 32'h0, 1'b0, lat_b, rd_b);
        join
        chk("t6_a_lat", lat_a, 3);
        chk("t6_a_data", rd_a, 32'h5555AAAA);
        chk("t6_b_data", rd_b, 32'hDEADABEF);
        chk("t6_first", (ack_log.size() > 0) ? ack_log[0] : 9, 0);

        // 6b: three-cycle RAM instance
        tx2(1'b1, 8'h05, 32'h12345678, lat, rd);
        chk("d2_wr_lat", lat, 2);
        tx2(1'b0, 8'h05, 32'h0, lat, rd);
        chk("d2_rd_lat", lat, 5);
        chk("d2_rd_data", rd, 32'h12345678);
        chk("d2_b_quiet", {d2_back, d2_brdat[30:0]}, 32'h0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
